cmd_master: RTL
===============

CMD_MASTER -- requirements
Module: cmd_master

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: request buffer depth in entries; power of two, >= 2.
REQ-002 Parameter IDLE_CMD, default 4'd0: cmd value driven when no beat is on the bus.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req_valid  input  1  request offered this cycle.
REQ-006 req_ready  output  1  request can be accepted this cycle.
REQ-007 req_cmd  input  4  command of the offered request.
REQ-008 req_adr  input  4  start address of the offered request.
REQ-009 req_data  input  4  first-beat data of the offered request.
REQ-010 req_len  input  2  burst length minus one (0 = 1 beat, 3 = 4 beats).
REQ-011 cmd  output  4  bus command, registered; bus-master side of the cmd/adr/data bus.
REQ-012 adr  output  4  bus address, registered.
REQ-013 data  output  4  bus data, registered.
REQ-014 busy  output  1  high while a beat is on the bus or the FIFO is non-empty.
REQ-015 txn_done  output  1  single-cycle pulse, coincident with the last beat of each burst.

Function
REQ-016 A request is accepted on a posedge where req_valid && req_ready.
REQ-017 req_ready SHALL equal !fifo_full; there is no dependency on req_valid.
REQ-018 An accepted request with req_cmd == IDLE_CMD SHALL be discarded: no FIFO write, no beats, no txn_done.
REQ-019 Other accepted requests SHALL be written to the FIFO as {cmd, adr, data, len} on the accepting edge.
REQ-020 FSM states: IDLE and DRIVE.
REQ-021 IDLE: outputs are cmd=IDLE_CMD, adr=0, data=0. If the FIFO is non-empty, pop the head, load beat 0 into the output registers and go to DRIVE.
REQ-022 DRIVE: each cycle presents one beat. Beat k SHALL carry cmd=head.cmd, adr=(head.adr+k) mod 16 and data=(head.data+k) mod 16, for k = 0..len.
REQ-023 On the last beat (k == len), assert txn_done. If the FIFO is non-empty, pop and load the next burst's beat 0 on the next edge with no idle gap; otherwise return to IDLE.
REQ-024 Latency: with an empty FIFO in IDLE, a request accepted at edge N SHALL have beat 0 visible on the bus after edge N+1.
REQ-025 A push and a pop on the same edge leave the occupancy unchanged. Push is impossible when full because req_ready is low.
REQ-026 The address and data wrap at 16 silently: adr 15 is followed by adr 0.
REQ-027 The beat counter is 2 bits and resets to 0 at each burst load.
REQ-028 busy SHALL be the combinational OR of (state == DRIVE) and !fifo_empty.

Reset
REQ-029 While rst is high, SHALL hold: state=IDLE, FIFO empty, beat counter 0, cmd=IDLE_CMD, adr=0, data=0, txn_done=0, busy=0 and req_ready=1.
REQ-030 Reset asserted mid-burst SHALL abort the burst immediately and drop all FIFO contents, with no txn_done.
REQ-031 The first request is acceptable on the first posedge after rst deasserts.

Structure
REQ-032 Shared package bus_pkg SHALL hold: the 4-bit field typedefs, the 2-bit length typedef, the request struct {cmd, adr, data, len}, and the state enum {IDLE, DRIVE}.
REQ-033 The FIFO SHALL be a separate sub-module cmd_fifo (parameterised depth, push/pop, full/empty, asynchronous active-high reset). The FSM and output registers stay in cmd_master.

Verification
REQ-034 Single beat: cmd=5, adr=3, data=9, len=0 accepted at edge N -> after edge N+1 the bus shows 5/3/9 with txn_done=1 for one cycle; after edge N+2 the bus shows IDLE_CMD/0/0.
REQ-035 Wrap burst: cmd=2, adr=14, data=15, len=3 -> beats adr 14,15,0,1 and data 15,0,1,2; txn_done only on the 4th beat.
REQ-036 Back-to-back: two len=1 requests on consecutive cycles -> 4 contiguous beats with no IDLE_CMD cycle; txn_done on beats 2 and 4.
REQ-037 Full: 6 requests offered with req_valid held high while a len=3 burst drives -> req_ready falls when 4 entries are buffered; no request is lost or duplicated; all bursts appear in order.
REQ-038 Discard: request with cmd=0 (IDLE_CMD) -> accepted, FIFO occupancy unchanged, no beats, busy stays 0.
REQ-039 Reset mid-burst: rst asserted on the 2nd beat of a len=3 burst, with 2 entries queued -> bus shows IDLE_CMD/0/0 immediately; busy=0 and req_ready=1; no further beats after rst deasserts.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types for the command bus master: field typedefs, request record and FSM states.
package bus_pkg;

    typedef logic [3:0] cmd_t;
    typedef logic [3:0] adr_t;
    typedef logic [3:0] dat_t;
    typedef logic [1:0] len_t;

    typedef struct packed {
        cmd_t cmd;
        adr_t adr;
        dat_t data;
        len_t len;
    } req_t;

    typedef enum logic {IDLE, DRIVE} state_t;

    // Address and data advance by one per beat and wrap silently at 16.
    function automatic logic [3:0] wrap_inc(input logic [3:0] v);
        return v + 4'd1;
    endfunction

endpackage

// File: rtl/cmd_master_if.sv
// Request handshake plus cmd/adr/data bus seen by cmd_master and whoever drives it.
interface cmd_master_if;
    import bus_pkg::*;

    logic req_valid;
    logic req_ready;
    cmd_t req_cmd;
    adr_t req_adr;
    dat_t req_data;
    len_t req_len;
    cmd_t cmd;
    adr_t adr;
    dat_t data;
    logic busy;
    logic txn_done;

    modport master (
        input  req_valid, req_cmd, req_adr, req_data, req_len,
        output req_ready, cmd, adr, data, busy, txn_done
    );

    modport slave (
        output req_valid, req_cmd, req_adr, req_data, req_len,
        input  req_ready, cmd, adr, data, busy, txn_done
    );

endinterface

// File: rtl/cmd_fifo.sv
// Request FIFO with wrap-bit pointers; head entry is presented combinationally.
module cmd_fifo
    import bus_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic pop,
    input  req_t wdata,
    output req_t rdata,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    req_t        mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage carries no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/cmd_master.sv
// Buffers burst requests and plays each one out on the registered cmd/adr/data bus.
module cmd_master
    import bus_pkg::*;
#(
    parameter int   FIFO_DEPTH = 4,
    parameter cmd_t IDLE_CMD   = 4'd0
) (
    input  logic         clk,
    input  logic         rst,
    cmd_master_if.master bus
);

    state_t state, state_n;
    cmd_t   cmd_q, cmd_n;
    adr_t   adr_q, adr_n;
    dat_t   data_q, data_n;
    len_t   len_q, len_n;
    len_t   cnt_q, cnt_n;
    logic   done_q, done_n;
    logic   push, pop, load, full, empty;
    req_t   head, wreq;

    assign bus.req_ready = !full;
    // Idle-command requests are still handshaken, just never stored.
    assign push = bus.req_valid && !full && (bus.req_cmd != IDLE_CMD);
    assign wreq = '{cmd: bus.req_cmd, adr: bus.req_adr, data: bus.req_data, len: bus.req_len};

    cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (wreq),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        state_n = state;
        cmd_n   = cmd_q;
        adr_n   = adr_q;
        data_n  = data_q;
        len_n   = len_q;
        cnt_n   = cnt_q;
        done_n  = 1'b0;
        load    = 1'b0;
        pop     = 1'b0;
        case (state)
            IDLE: load = !empty;
            DRIVE: begin
                if (cnt_q == len_q) begin
                    if (!empty) begin
                        load = 1'b1;
                    end else begin
                        state_n = IDLE;
                        cmd_n   = IDLE_CMD;
                        adr_n   = '0;
                        data_n  = '0;
                        cnt_n   = '0;
                    end
                end else begin
                    cnt_n  = cnt_q + 2'd1;
                    adr_n  = wrap_inc(adr_q);
                    data_n = wrap_inc(data_q);
                    done_n = (cnt_n == len_q);
                end
            end
            default: state_n = IDLE;
        endcase
        // Loading beat 0 of the head burst; also chains bursts with no idle gap.
        if (load) begin
            pop     = 1'b1;
            state_n = DRIVE;
            cmd_n   = head.cmd;
            adr_n   = head.adr;
            data_n  = head.data;
            len_n   = head.len;
            cnt_n   = '0;
            done_n  = (head.len == 2'd0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cmd_q  <= IDLE_CMD;
            adr_q  <= '0;
            data_q <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            cmd_q  <= cmd_n;
            adr_q  <= adr_n;
            data_q <= data_n;
            cnt_q  <= cnt_n;
            done_q <= done_n;
        end
    end

    // Burst length is only consulted in DRIVE, after a load has written it.
    always_ff @(posedge clk) begin
        len_q <= len_n;
    end

    assign bus.cmd      = cmd_q;
    assign bus.adr      = adr_q;
    assign bus.data     = data_q;
    assign bus.txn_done = done_q;
    assign bus.busy     = (state == DRIVE) || !empty;

endmodule
